// File: rtl/fifo_rd_stream_if.sv
// Output stream bundle for the FIFO read adapter: valid/ready, data and packet-last flag.
// Latency: none, this is a plain wire bundle.
// Backpressure: the consumer holds m_ready low and the producer keeps m_valid/m_data stable.
interface fifo_rd_stream_if #(
    parameter int BITS = 32
);
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic            m_last;

    // Producer side: drives the word, samples the consumer's ready
    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    // Consumer side: samples the word, drives ready
    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Converts the async FIFO pop port (1-cycle registered read) into a valid/ready stream with a 2-entry skid buffer.
// Latency: empty falls in cycle N -> pop in N -> capture at end of N+1 -> m_valid in N+2; then 1 word/cycle.
// Backpressure: pops only while buffered + in-flight words stay <= 2, so m_ready low stalls after 2 pops.
// Optional packet framing (m_last every PKT_LEN beats) is built when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream #(
    parameter int BITS     = 32,
    parameter int PKT_LEN  = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    output logic                fifo_rd_en,
    input  logic [BITS-1:0]     fifo_rd_data,
    input  logic                fifo_rd_empty,
    fifo_rd_stream_if.master    m,
    output logic [CNT_BITS-1:0] beat_cnt
);

    logic [1:0]      occ;       // words held in the buffer (0..2)
    logic            inflight;  // a pop was issued last cycle; its data arrives now
    logic [BITS-1:0] head_q;    // oldest word, presented on m_data
    logic [BITS-1:0] tail_q;    // second word, valid only when occ == 2
    logic            fire;
    logic [2:0]      pending;   // words that will be owned after this cycle's fire

    assign fire      = m.m_valid && m.m_ready;
    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = head_q;

    // A word leaving this cycle frees a slot for a pop in the same cycle,
    // which is what keeps full throughput at occ == 1 with m_ready high.
    assign pending    = {1'b0, occ} + {2'b0, inflight} - {2'b0, fire};
    assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && (pending < 3'd2);

    // Occupancy bookkeeping: capture adds one, fire removes one
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            occ      <= occ + {1'b0, inflight} - {1'b0, fire};
            inflight <= fifo_rd_en;
        end
    end

    // Buffer data movement; fifo_rd_data is only looked at when a pop is in flight
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (fire) begin
            if (occ == 2'd2) begin
                head_q <= tail_q;
                if (inflight) begin
                    tail_q <= fifo_rd_data;
                end
            end else if (inflight) begin
                head_q <= fifo_rd_data;
            end
            // occ == 1 with no capture: head keeps its value while m_valid drops
        end else if (inflight) begin
            // occ + inflight <= 2 guarantees occ is 0 or 1 here
            if (occ == 2'd0) begin
                head_q <= fifo_rd_data;
            end else begin
                tail_q <= fifo_rd_data;
            end
        end
    end

    // Saturating count of delivered beats
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            beat_cnt <= '0;
        end else if (fire && (beat_cnt != {CNT_BITS{1'b1}})) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0] PKT_MAX = PW'(PKT_LEN - 1);

    logic [PW-1:0] pkt_cnt;

    // Position of the head word within its packet, wrapping after PKT_LEN beats
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            pkt_cnt <= '0;
        end else if (fire) begin
            pkt_cnt <= (pkt_cnt == PKT_MAX) ? '0 : pkt_cnt + 1'b1;
        end
    end

    assign m.m_last = m.m_valid && (pkt_cnt == PKT_MAX);
`else
    assign m.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: models the FIFO as a word queue, scoreboards delivered words.
// Driver changes inputs 1 time unit after rd_clk rises; the monitor samples on the falling edge.
// Build with or without FIFO_RD_STREAM_LAST_EN; PKT_LEN is 4 here.
module tb_fifo_rd_stream;
    localparam int BITS     = 32;
    localparam int PKT_LEN  = 4;
    localparam int CNT_BITS = 16;
`ifdef FIFO_RD_STREAM_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic                rd_clk = 1'b0;
    logic                rd_rst_n;
    logic                fifo_rd_en;
    logic [BITS-1:0]     fifo_rd_data;
    logic                fifo_rd_empty;
    logic [CNT_BITS-1:0] beat_cnt;

    fifo_rd_stream_if #(.BITS(BITS)) s_if ();

    fifo_rd_stream #(.BITS(BITS), .PKT_LEN(PKT_LEN), .CNT_BITS(CNT_BITS)) dut (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m             (s_if.master),
        .beat_cnt      (beat_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] fq[$];     // contents of the modelled FIFO
    logic [BITS-1:0] exp_q[$];  // words still owed to the stream, in order

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- driver state ----------------
    bit rand_ready = 0;
    bit rand_gap   = 0;
    bit ready_fix  = 0;
    int ncyc       = 0;
    int drv_pops   = 0;
    bit s_rd_en, s_pop, s_valid, s_fire;
    logic [BITS-1:0] s_data;

    // One clock: snapshot at the falling edge, then model the FIFO pop and drive new inputs
    task automatic cycle();
        bit pop;
        @(negedge rd_clk);
        ncyc++;
        s_rd_en = fifo_rd_en;
        s_pop   = rd_rst_n && fifo_rd_en && !fifo_rd_empty;
        s_valid = s_if.m_valid;
        s_fire  = s_if.m_valid && s_if.m_ready;
        s_data  = s_if.m_data;
        pop     = s_pop;
        @(posedge rd_clk);
        #1;
        if (pop) begin
            fifo_rd_data = fq.pop_front();
            drv_pops++;
        end else begin
            fifo_rd_data = $urandom;  // the adapter must not look at the bus this cycle
        end
        s_if.m_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
        fifo_rd_empty = (fq.size() == 0) || (rand_gap && ($urandom_range(0, 3) == 0));
    endtask

    task automatic load(input logic [BITS-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int mon_pops  = 0;
    int mon_fires = 0;
    bit prev_valid = 0;
    bit prev_fire  = 0;
    logic [BITS-1:0] prev_data;

    // Protocol, occupancy, counter, framing and data checks every cycle
    always @(negedge rd_clk) begin
        bit fire, pop, want_last;
        logic [BITS-1:0] w;
        int own;
        if (!rd_rst_n) begin
            mon_pops   = 0;
            mon_fires  = 0;
            prev_valid = 0;
            prev_fire  = 0;
        end else begin
            fire = s_if.m_valid && s_if.m_ready;
            pop  = fifo_rd_en && !fifo_rd_empty;
            chk("pop_while_empty", {63'd0, fifo_rd_en && fifo_rd_empty}, 64'd0);
            own = (mon_pops + int'(pop)) - (mon_fires + int'(fire));
            chk("occupancy_le_2", {63'd0, own <= 2}, 64'd1);
            if (prev_valid && !prev_fire) begin
                chk("valid_hold", {63'd0, s_if.m_valid}, 64'd1);
                chk("data_hold", {32'd0, s_if.m_data}, {32'd0, prev_data});
            end
            chk("beat_cnt", {48'd0, beat_cnt}, (mon_fires > 65535) ? 64'd65535 : 64'(mon_fires));
            want_last = LAST_EN && s_if.m_valid && ((mon_fires % PKT_LEN) == PKT_LEN - 1);
            chk("m_last", {63'd0, s_if.m_last}, {63'd0, want_last});
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {32'd0, s_if.m_data}, 64'hdead_beef_dead_beef);
                end else begin
                    w = exp_q.pop_front();
                    chk("data", {32'd0, s_if.m_data}, {32'd0, w});
                end
            end
            mon_pops   += int'(pop);
            mon_fires  += int'(fire);
            prev_valid = s_if.m_valid;
            prev_fire  = fire;
            prev_data  = s_if.m_data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int first_pop, first_valid, last_fire, nfire, p0;
        rd_rst_n      = 1'b0;
        fifo_rd_data  = '0;
        s_if.m_ready  = 1'b1;
        for (int i = 1; i <= 16; i++) load(BITS'(i));
        fifo_rd_empty = 1'b0;

        // Reset holds everything quiet even with data available
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("rst_m_valid", {63'd0, s_if.m_valid}, 64'd0);
        chk("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
        chk("rst_m_data", {32'd0, s_if.m_data}, 64'd0);
        chk("rst_m_last", {63'd0, s_if.m_last}, 64'd0);
        @(posedge rd_clk);
        #1;
        rd_rst_n  = 1'b1;
        ready_fix = 1'b1;

        // Streaming 0x1..0x10 with m_ready high
        first_pop = -1; first_valid = -1; last_fire = -1; nfire = 0;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            cycle();
            if (n == 0) chk("first_rd_en_after_reset", {63'd0, s_rd_en}, 64'd1);
            if (s_pop && first_pop < 0) first_pop = ncyc;
            if (s_valid && first_valid < 0) first_valid = ncyc;
            if (s_fire) begin nfire++; last_fire = ncyc; end
        end
        chk("stream_latency", 64'(first_valid - first_pop), 64'd2);
        chk("stream_fires", 64'(nfire), 64'd16);
        chk("stream_back_to_back", 64'(last_fire - first_valid + 1), 64'd16);
        cycle();
        chk("stream_beat_cnt", {48'd0, beat_cnt}, 64'd16);

        // Backpressure: 8 words ready, consumer stalled for 10 cycles
        ready_fix    = 1'b0;
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(32'h100 + BITS'(i));
        p0 = drv_pops;
        repeat (10) cycle();
        chk("bp_pops", 64'(drv_pops - p0), 64'd2);
        chk("bp_valid", {63'd0, s_valid}, 64'd1);
        chk("bp_head", {32'd0, s_data}, 64'h100);
        ready_fix    = 1'b1;
        s_if.m_ready = 1'b1;
        cycle();
        chk("bp_release_fire", {63'd0, s_fire}, 64'd1);
        chk("bp_release_pop", {63'd0, s_pop}, 64'd1);
        drain("bp_drain", 100);

        // Random ready and random FIFO empty gaps over 1000 words
        rand_ready = 1;
        rand_gap   = 1;
        for (int i = 0; i < 1000; i++) load(BITS'($urandom));
        drain("rand_drain", 8000);
        rand_ready = 0;
        rand_gap   = 0;

        // Reset with the buffer full and the consumer stalled
        ready_fix    = 1'b0;
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(32'h200 + BITS'(i));
        repeat (4) cycle();
        chk("mid_full_valid", {63'd0, s_valid}, 64'd1);
        rd_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, s_if.m_valid}, 64'd0);
        chk("mid_rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
        chk("mid_rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        fq.delete();
        exp_q.delete();
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;

        // Recovery after reset, also exercises framing from a fresh packet count
        ready_fix    = 1'b1;
        s_if.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) load(32'h300 + BITS'(i));
        drain("post_reset_drain", 100);
        cycle();
        chk("post_reset_beat_cnt", {48'd0, beat_cnt}, 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
